alu_arbiter: RTL and testbench
==============================

// Module: alu_arbiter
// PURPOSE
//   Shares one alu instance between NREQ requesters, e.g. the main execute path and an address/branch-target helper.
//   Each requester issues {op,a,b} on a valid/ready request channel. It receives a registered 32-bit result on a
//   valid/ready response channel. Arbitration is round-robin with at most one operation in flight.
// PARAMETERS
//   NREQ     2    number of requesters, legal range 2..8
//   GNT_W    3    width of the grant index; must satisfy 2**GNT_W >= NREQ
// PORTS
//   clk          in   1          single clock, rising edge
//   rst_n        in   1          asynchronous active-low reset
//   req_valid    in   NREQ       per-requester request valid
//   req_ready    out  NREQ       one-hot accept pulse, combinational in IDLE
//   req_op       in   4*NREQ     alu_op codes from def.v (ADD..SLTU), requester i at [4i+3:4i]
//   req_a        in   32*NREQ    operand a, requester i at [32i+31:32i]
//   req_b        in   32*NREQ    operand b, same slicing as req_a
//   rsp_valid    out  NREQ       one-hot response valid for the owning requester
//   rsp_ready    in   NREQ       per-requester response accept
//   rsp_data     out  32         result, shared by all requesters, qualified by rsp_valid
//   rsp_err      out  1          illegal-op flag, qualified by rsp_valid (see CONFIGURATION)
//   busy         out  1          high in EXEC or RESP
// BEHAVIOUR
//   Reset (async, rst_n=0):
//     - outputs: state=IDLE, req_ready=0, rsp_valid=0, rsp_data=0, rsp_err=0, busy=0
//     - internal: operand/op regs=0, last_gnt=NREQ-1, so requester 0 wins first
//     - reset mid-operation discards the transaction; no response is ever issued for it
//   FSM, 3 states:
//     - IDLE: if |req_valid, pick the first set bit scanning from last_gnt+1 modulo NREQ.
//       Drive req_ready[g]=1 in the same cycle. Latch op/a/b[g], gnt<=g, last_gnt<=g, go to EXEC.
//       If no request, stay in IDLE with req_ready=0.
//     - EXEC: the alu sees the latched op/a/b. Capture alu c into rsp_data on the clock edge, go to RESP.
//     - RESP: rsp_valid[gnt]=1; rsp_data and rsp_err stay stable. When rsp_ready[gnt]=1, go to IDLE
//       and drop rsp_valid on the next cycle.
//   Latency and throughput:
//     - request accepted at edge T -> rsp_valid high in cycle T+2
//     - back-to-back issue gives one operation per 3 cycles minimum
//   Handshake rules:
//     - requesters hold valid and payload stable until ready
//     - the block never uses the payload of a request that has not been granted
//     - rsp_ready from a non-owner, or any rsp_ready outside RESP, is ignored
//     - req_valid seen during EXEC or RESP is not accepted; it waits for IDLE
//     - a requester may have a new request pending while its own response is still in RESP
//   Arithmetic: the alu alone defines the results; the arbiter adds no width changes, and rsp_data = alu c unchanged.
//   Fairness: a requester held valid is granted within NREQ grants.
// CONFIGURATION
//   ALU_ARB_OPCHK_EN
//     - defined: an op outside the def.v set {ADD,ADDU,SUBU,AND,OR,SLT,LUI,BEQ,SRAV,SLTU} still completes
//       the full handshake, with rsp_data=0 and rsp_err=1
//     - undefined: rsp_err is tied to 0; rsp_data for an illegal op is whatever the alu presents, which is
//       not guaranteed
// STRUCTURE
//   Shared definitions:
//     - alu_op codes come from def.v
//     - add to def.v: ARB_IDLE=2'd0, ARB_EXEC=2'd1, ARB_RESP=2'd2
//   Sub-modules:
//     - one natural sub-module, rr_pick: combinational round-robin picker, NREQ-bit request vector plus
//       last_gnt in -> one-hot grant plus index out
//     - alu instantiated directly on the latched operand registers
// TESTING
//   1. Reset, then req_valid=01 with ADDU a=5 b=7: req_ready=01 in the accept cycle; rsp_valid=01 two cycles
//      later with rsp_data=12.
//   2. Both valid continuously with ops SUBU(10,3) and SLT(-1,1): grants alternate 0,1,0,1; responses 7 and 1;
//      no requester is starved.
//   3. Hold rsp_ready=0 for 5 cycles in RESP: rsp_valid and rsp_data are stable; a new req_valid on the other
//      port sees req_ready=0 until the handshake completes.
//   4. LUI b=0x1234 -> 0x12340000; SRAV a=4 b=0x80000000 -> 0xF8000000; SLTU a=0xFFFFFFFF b=1 -> 0.
//   5. Pulse rst_n low while in EXEC: rsp_valid never rises for that request; the next grant goes to
//      requester 0.
//   6. With ALU_ARB_OPCHK_EN, op=4'hF: rsp_valid with rsp_err=1 and rsp_data=0. Without the macro: rsp_err
//      is always 0.

Source files
------------

// File: rtl/alu_arbiter_pkg.sv
// alu_arbiter_pkg
//   Shared definitions for the ALU arbiter slice. This holds the alu_op
//   encodings (ADD..SLTU) and the arbiter FSM state encoding
//   (ARB_IDLE/ARB_EXEC/ARB_RESP). It also provides a helper that tells
//   whether an op code is part of the defined set.
//   Optional feature macro used by the arbiter: ALU_ARB_OPCHK_EN.

package alu_arbiter_pkg;

    // alu_op encodings
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_ADDU = 4'd1;
    localparam logic [3:0] ALU_SUBU = 4'd2;
    localparam logic [3:0] ALU_AND  = 4'd3;
    localparam logic [3:0] ALU_OR   = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_LUI  = 4'd6;
    localparam logic [3:0] ALU_BEQ  = 4'd7;
    localparam logic [3:0] ALU_SRAV = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_EXEC = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_t;

    // The defined op codes are contiguous from ADD up to SLTU.
    function automatic logic op_is_legal(input logic [3:0] op);
        return (op <= ALU_SLTU);
    endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// alu
//   Combinational 32-bit ALU shared by the arbiter's requesters.
//   Ports:
//     op  in  4   alu_op code (see alu_arbiter_pkg)
//     a   in  32  operand a (also the shift amount for SRAV)
//     b   in  32  operand b (also the shifted value for SRAV and the LUI immediate)
//     c   out 32  result; an undefined op code yields 0
//   ADD does not trap on overflow here, so it computes the same result as ADDU.
//   BEQ produces a - b, and the consumer tests that result for zero.

module alu
    import alu_arbiter_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] c
);

    always_comb begin
        c = '0;
        case (op)
            ALU_ADD:  c = a + b;
            ALU_ADDU: c = a + b;
            ALU_SUBU: c = a - b;
            ALU_AND:  c = a & b;
            ALU_OR:   c = a | b;
            ALU_SLT:  c = {31'b0, ($signed(a) < $signed(b))};
            ALU_LUI:  c = {b[15:0], 16'b0};
            ALU_BEQ:  c = a - b;
            ALU_SRAV: c = $signed(b) >>> a[4:0];
            ALU_SLTU: c = {31'b0, (a < b)};
            default:  c = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter_rr_pick.sv
// rr_pick
//   Combinational round-robin picker. It searches the request vector
//   starting one position after last_gnt, wraps around modulo NREQ, and
//   returns the first set bit.
//   Ports:
//     req       in   NREQ   request vector
//     last_gnt  in   GNT_W  index of the most recent grant
//     gnt_oh    out  NREQ   one-hot grant (all zero when no request)
//     gnt_idx   out  GNT_W  index of the granted requester
//     gnt_any   out  1      at least one request present

module rr_pick #(
    parameter int NREQ  = 2,
    parameter int GNT_W = 3
) (
    input  logic [NREQ-1:0]  req,
    input  logic [GNT_W-1:0] last_gnt,
    output logic [NREQ-1:0]  gnt_oh,
    output logic [GNT_W-1:0] gnt_idx,
    output logic             gnt_any
);

    // Candidate k is (last_gnt + k) mod NREQ. The inner loop matches that
    // candidate against constant bit positions, so every index stays static.
    always_comb begin
        int cand;
        gnt_oh  = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        cand    = 0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = (int'(last_gnt) + k) % NREQ;
            for (int j = 0; j < NREQ; j++) begin
                if (!gnt_any && (j == cand) && req[j]) begin
                    gnt_any    = 1'b1;
                    gnt_oh[j]  = 1'b1;
                    gnt_idx    = GNT_W'(j);
                end
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Shares one alu between NREQ requesters with round-robin arbitration.
//   At most one operation is in flight at a time. Each operation takes
//   IDLE (accept) -> EXEC (alu result captured) -> RESP (held until the
//   owner accepts the response).
//   Parameters: NREQ (2..8), GNT_W (2**GNT_W >= NREQ).
//   Ports:
//     clk        in   1        rising-edge clock
//     rst_n      in   1        asynchronous active-low reset
//     req_valid  in   NREQ     per-requester request valid
//     req_ready  out  NREQ     one-hot accept, combinational in IDLE
//     req_op     in   4*NREQ   op of requester i at [4i+3:4i]
//     req_a      in   32*NREQ  operand a of requester i at [32i+31:32i]
//     req_b      in   32*NREQ  operand b, same slicing
//     rsp_valid  out  NREQ     one-hot response valid for the owner
//     rsp_ready  in   NREQ     per-requester response accept
//     rsp_data   out  32       registered result, qualified by rsp_valid
//     rsp_err    out  1        illegal-op flag, qualified by rsp_valid
//     busy       out  1        high in EXEC or RESP
//   Macro ALU_ARB_OPCHK_EN: when defined, an undefined op returns
//   rsp_data=0 with rsp_err=1. Otherwise rsp_err is tied low.

module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int GNT_W = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [4*NREQ-1:0]  req_op,
    input  logic [32*NREQ-1:0] req_a,
    input  logic [32*NREQ-1:0] req_b,
    output logic [NREQ-1:0]    rsp_valid,
    input  logic [NREQ-1:0]    rsp_ready,
    output logic [31:0]        rsp_data,
    output logic               rsp_err,
    output logic               busy
);

    arb_state_t       state_q, state_d;
    logic [3:0]       op_q;
    logic [31:0]      a_q, b_q;
    logic [NREQ-1:0]  gnt_oh_q;
    logic [GNT_W-1:0] last_gnt_q;
    logic [31:0]      rsp_data_q;

    logic [NREQ-1:0]  pick_oh;
    logic [GNT_W-1:0] pick_idx;
    logic             pick_any;
    logic [3:0]       op_sel;
    logic [31:0]      a_sel, b_sel;
    logic [31:0]      alu_c;
    logic             owner_ready;
    logic             load;
    logic             capture;

    rr_pick #(
        .NREQ  (NREQ),
        .GNT_W (GNT_W)
    ) u_rr_pick (
        .req      (req_valid),
        .last_gnt (last_gnt_q),
        .gnt_oh   (pick_oh),
        .gnt_idx  (pick_idx),
        .gnt_any  (pick_any)
    );

    // The one-hot grant selects the payload with an AND-OR mux. A requester
    // that is not granted therefore contributes nothing to the latched operands.
    always_comb begin
        op_sel = '0;
        a_sel  = '0;
        b_sel  = '0;
        for (int i = 0; i < NREQ; i++) begin
            op_sel = op_sel | (req_op[4*i +: 4]  & {4{pick_oh[i]}});
            a_sel  = a_sel  | (req_a[32*i +: 32] & {32{pick_oh[i]}});
            b_sel  = b_sel  | (req_b[32*i +: 32] & {32{pick_oh[i]}});
        end
    end

    // Only the current owner's rsp_ready can complete the response.
    assign owner_ready = |(rsp_ready & gnt_oh_q);

    alu u_alu (
        .op (op_q),
        .a  (a_q),
        .b  (b_q),
        .c  (alu_c)
    );

    // Next-state and handshake decode
    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        load      = 1'b0;
        capture   = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (pick_any) begin
                    req_ready = pick_oh;
                    load      = 1'b1;
                    state_d   = ARB_EXEC;
                end
            end
            ARB_EXEC: begin
                capture = 1'b1;
                state_d = ARB_RESP;
            end
            ARB_RESP: begin
                if (owner_ready) begin
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // State, grant bookkeeping and operand latches. last_gnt resets to
    // NREQ-1 so that requester 0 is first in the scan after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ARB_IDLE;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            gnt_oh_q   <= '0;
            last_gnt_q <= GNT_W'(NREQ - 1);
        end else begin
            state_q <= state_d;
            if (load) begin
                op_q       <= op_sel;
                a_q        <= a_sel;
                b_q        <= b_sel;
                gnt_oh_q   <= pick_oh;
                last_gnt_q <= pick_idx;
            end
        end
    end

`ifdef ALU_ARB_OPCHK_EN
    logic rsp_err_q;

    // An undefined op still completes the handshake, but its result is
    // forced to zero and the error flag is raised.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else if (capture) begin
            rsp_data_q <= op_is_legal(op_q) ? alu_c : 32'h0;
            rsp_err_q  <= !op_is_legal(op_q);
        end
    end

    assign rsp_err = rsp_err_q;
`else
    // Capture the alu result unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_data_q <= '0;
        end else if (capture) begin
            rsp_data_q <= alu_c;
        end
    end

    assign rsp_err = 1'b0;
`endif

    assign rsp_data  = rsp_data_q;
    assign rsp_valid = (state_q == ARB_RESP) ? gnt_oh_q : '0;
    assign busy      = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter
//   Directed testbench for alu_arbiter with NREQ=2. Every expected value
//   is a hand-computed constant.
//   Honors ALU_ARB_OPCHK_EN for the illegal-op case.

module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [7:0]  req_op;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        busy;

    int check_count = 0;
    int error_count = 0;

    alu_arbiter #(
        .NREQ  (2),
        .GNT_W (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] actual,
                                input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction on a single requester. The request is accepted
    // in the first cycle where ready is seen, and the response is expected
    // two edges later.
    task automatic apply_stimulus(input int idx, input logic [3:0] op,
                                  input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] exp_data, input logic exp_err,
                                  input bit chk_data, input string tag);
        int waited;
        req_valid[idx]       = 1'b1;
        req_op[4*idx +: 4]   = op;
        req_a[32*idx +: 32]  = a;
        req_b[32*idx +: 32]  = b;
        #1;
        waited = 0;
        while (req_ready[idx] !== 1'b1 && waited < 20) begin
            tick();
            waited++;
        end
        check_output({tag, "_grant"}, 32'(req_ready[idx]), 32'd1);
        tick();
        req_valid[idx] = 1'b0;
        check_output({tag, "_exec_busy"}, 32'(busy), 32'd1);
        check_output({tag, "_exec_rspv"}, 32'(rsp_valid), 32'd0);
        tick();
        check_output({tag, "_rspv"}, 32'(rsp_valid), 32'd1 << idx);
        if (chk_data) begin
            check_output({tag, "_data"}, rsp_data, exp_data);
        end
        check_output({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
        rsp_ready[idx] = 1'b1;
        tick();
        rsp_ready = 2'b00;
        check_output({tag, "_done_rspv"}, 32'(rsp_valid), 32'd0);
        check_output({tag, "_done_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;

        // Reset state
        #2;
        check_output("rst_req_ready", 32'(req_ready), 32'd0);
        check_output("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_output("rst_rsp_data", rsp_data, 32'd0);
        check_output("rst_rsp_err", 32'(rsp_err), 32'd0);
        check_output("rst_busy", 32'(busy), 32'd0);
        #20;
        rst_n = 1'b1;
        tick();

        // 1: single ADDU 5+7 on requester 0
        $display("[TB] test 1: ADDU on requester 0");
        req_valid = 2'b01;
        req_op[3:0] = ALU_ADDU;
        req_a[31:0] = 32'd5;
        req_b[31:0] = 32'd7;
        #1;
        check_output("t1_accept", 32'(req_ready), 32'd1);
        tick();
        req_valid = 2'b00;
        check_output("t1_exec_ready", 32'(req_ready), 32'd0);
        check_output("t1_exec_rspv", 32'(rsp_valid), 32'd0);
        tick();
        check_output("t1_rspv", 32'(rsp_valid), 32'd1);
        check_output("t1_data", rsp_data, 32'd12);
        check_output("t1_busy", 32'(busy), 32'd1);
        rsp_ready = 2'b01;
        tick();
        rsp_ready = 2'b00;
        check_output("t1_idle_rspv", 32'(rsp_valid), 32'd0);

        // 2: both requesters valid continuously. The last grant went to 0,
        //    so the sequence is 1,0,1,0.
        $display("[TB] test 2: round robin");
        req_valid = 2'b11;
        req_op    = {ALU_SLT, ALU_SUBU};
        req_a     = {32'hFFFF_FFFF, 32'd10};
        req_b     = {32'd1, 32'd3};
        rsp_ready = 2'b11;
        for (int k = 0; k < 4; k++) begin
            int g;
            g = (k % 2 == 0) ? 1 : 0;
            #1;
            check_output($sformatf("t2_grant%0d", k), 32'(req_ready), 32'd1 << g);
            tick();
            tick();
            check_output($sformatf("t2_rspv%0d", k), 32'(rsp_valid), 32'd1 << g);
            check_output($sformatf("t2_data%0d", k), rsp_data, (g == 1) ? 32'd1 : 32'd7);
            tick();
        end
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        tick();

        // 3: response stall, a competing request and a non-owner rsp_ready
        $display("[TB] test 3: response stall");
        req_valid   = 2'b01;
        req_op[3:0] = ALU_ADD;
        req_a[31:0] = 32'd100;
        req_b[31:0] = 32'd23;
        #1;
        check_output("t3_accept", 32'(req_ready), 32'd1);
        tick();
        req_valid = 2'b00;
        tick();
        req_valid[1]   = 1'b1;
        req_op[7:4]    = ALU_AND;
        req_a[63:32]   = 32'h0000_F0F0;
        req_b[63:32]   = 32'h0000_FF00;
        rsp_ready      = 2'b10;
        for (int i = 0; i < 5; i++) begin
            #1;
            check_output($sformatf("t3_hold_rspv%0d", i), 32'(rsp_valid), 32'd1);
            check_output($sformatf("t3_hold_data%0d", i), rsp_data, 32'd123);
            check_output($sformatf("t3_hold_ready%0d", i), 32'(req_ready), 32'd0);
            tick();
        end
        rsp_ready = 2'b01;
        tick();
        rsp_ready = 2'b00;
        #1;
        check_output("t3_second_accept", 32'(req_ready), 32'd2);
        tick();
        req_valid = 2'b00;
        tick();
        check_output("t3_second_rspv", 32'(rsp_valid), 32'd2);
        check_output("t3_second_data", rsp_data, 32'h0000_F000);
        rsp_ready = 2'b10;
        tick();
        rsp_ready = 2'b00;

        // 4: boundary arithmetic
        $display("[TB] test 4: LUI/SRAV/SLTU");
        apply_stimulus(0, ALU_LUI,  32'd0, 32'h0000_1234, 32'h1234_0000, 1'b0, 1'b1, "t4_lui");
        apply_stimulus(0, ALU_SRAV, 32'd4, 32'h8000_0000, 32'hF800_0000, 1'b0, 1'b1, "t4_srav");
        apply_stimulus(0, ALU_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b1, "t4_sltu");

        // 5: reset during EXEC discards the operation
        $display("[TB] test 5: reset mid-operation");
        req_valid     = 2'b10;
        req_op[7:4]   = ALU_ADDU;
        req_a[63:32]  = 32'd1;
        req_b[63:32]  = 32'd1;
        #1;
        check_output("t5_accept", 32'(req_ready), 32'd2);
        tick();
        req_valid = 2'b00;
        check_output("t5_exec_busy", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("t5_rst_busy", 32'(busy), 32'd0);
        check_output("t5_rst_rspv", 32'(rsp_valid), 32'd0);
        check_output("t5_rst_data", rsp_data, 32'd0);
        tick();
        tick();
        #3;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_output($sformatf("t5_no_rsp%0d", i), 32'(rsp_valid), 32'd0);
        end
        req_valid   = 2'b11;
        req_op[3:0] = ALU_OR;
        req_a[31:0] = 32'h0000_000F;
        req_b[31:0] = 32'h0000_00F0;
        #1;
        check_output("t5_first_after_rst", 32'(req_ready), 32'd1);
        tick();
        req_valid = 2'b00;
        tick();
        check_output("t5_rspv", 32'(rsp_valid), 32'd1);
        check_output("t5_data", rsp_data, 32'h0000_00FF);
        rsp_ready = 2'b01;
        tick();
        rsp_ready = 2'b00;

        // 6: undefined op code
        $display("[TB] test 6: undefined op");
`ifdef ALU_ARB_OPCHK_EN
        apply_stimulus(0, 4'hF, 32'd1, 32'd2, 32'd0, 1'b1, 1'b1, "t6_illegal");
`else
        apply_stimulus(0, 4'hF, 32'd1, 32'd2, 32'd0, 1'b0, 1'b0, "t6_illegal");
`endif

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
